// File: rtl/operand_assembly_latch_if.sv
// Handshake/data bundle between the instruction decoder and operand_assembly_latch.
// The master side drives the decode strobes and bus data; the slave side is the latch.
interface operand_assembly_latch_if #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MAX_BYTES = 2,
    parameter int unsigned CNT_W     = 3
);
    logic                          start;
    logic [CNT_W-1:0]              expect_bytes;
    logic                          load;
    logic                          rwb;
    logic [DATA_W-1:0]             db_in;
    logic                          consume;
    logic                          clear;
    logic [DATA_W-1:0]             index_in;
    logic [DATA_W-1:0]             db_out;
    logic [DATA_W-1:0]             address_low_out;
    logic [DATA_W-1:0]             address_high_out;
    logic [DATA_W*MAX_BYTES-1:0]   operand_out;
    logic [CNT_W-1:0]              byte_ptr;
    logic                          busy;
    logic                          operand_valid;
    logic                          overflow;
    logic                          page_cross;

    modport master (
        output start, expect_bytes, load, rwb, db_in, consume, clear, index_in,
        input  db_out, address_low_out, address_high_out, operand_out, byte_ptr,
               busy, operand_valid, overflow, page_cross
    );

    modport slave (
        input  start, expect_bytes, load, rwb, db_in, consume, clear, index_in,
        output db_out, address_low_out, address_high_out, operand_out, byte_ptr,
               busy, operand_valid, overflow, page_cross
    );
endinterface

// File: rtl/operand_assembly_latch.sv
// Assembles a 1..MAX_BYTES little-endian operand from successive data-bus reads.
// Define OPERAND_INDEX_ADD_EN to add index_in to the address bytes via an extra INDEX state.
module operand_assembly_latch #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MAX_BYTES = 2,
    parameter int unsigned CNT_W     = 3
) (
    input logic fclk,
    input logic reset,
    operand_assembly_latch_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StCollect, StFull, StIndex} state_e;

`ifdef OPERAND_INDEX_ADD_EN
    localparam state_e StDone = StIndex;
`else
    localparam state_e StDone = StFull;
`endif

    localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_BYTES);

    state_e                              state_q, state_d;
    logic [MAX_BYTES-1:0][DATA_W-1:0]    lanes_q, lanes_d;
    logic [CNT_W-1:0]                    byte_ptr_q, byte_ptr_d;
    logic [CNT_W-1:0]                    n_q, n_d;
    logic                                overflow_q, overflow_d;
    logic [CNT_W-1:0]                    n_sat;
    logic                                capture;

`ifdef OPERAND_INDEX_ADD_EN
    logic [DATA_W-1:0] addr_lo_q, addr_lo_d;
    logic [DATA_W-1:0] addr_hi_q, addr_hi_d;
    logic              page_cross_q, page_cross_d;
    logic [DATA_W:0]   idx_sum;

    assign idx_sum = {1'b0, lanes_q[0]} + {1'b0, bus.index_in};
`else
    logic unused_index;
    assign unused_index = ^bus.index_in;
`endif

    assign n_sat   = (bus.expect_bytes > MaxCnt) ? MaxCnt : bus.expect_bytes;
    assign capture = bus.load && bus.rwb;

    always_comb begin
        state_d    = state_q;
        lanes_d    = lanes_q;
        byte_ptr_d = byte_ptr_q;
        n_d        = n_q;
        overflow_d = overflow_q;
`ifdef OPERAND_INDEX_ADD_EN
        addr_lo_d    = addr_lo_q;
        addr_hi_d    = addr_hi_q;
        page_cross_d = page_cross_q;
`endif
        if (bus.clear) begin
            state_d    = StIdle;
            lanes_d    = '0;
            byte_ptr_d = '0;
            overflow_d = 1'b0;
`ifdef OPERAND_INDEX_ADD_EN
            addr_lo_d    = '0;
            addr_hi_d    = '0;
            page_cross_d = 1'b0;
`endif
        end else if (bus.start) begin
            // Abort-restart: any same-cycle load is dropped.
            lanes_d    = '0;
            byte_ptr_d = '0;
            overflow_d = 1'b0;
            n_d        = n_sat;
            state_d    = (n_sat == '0) ? StDone : StCollect;
`ifdef OPERAND_INDEX_ADD_EN
            addr_lo_d = '0;
            addr_hi_d = '0;
`endif
        end else begin
            unique case (state_q)
                StCollect: begin
                    if (capture) begin
                        for (int i = 0; i < MAX_BYTES; i++) begin
                            if (byte_ptr_q == CNT_W'(i)) lanes_d[i] = bus.db_in;
                        end
                        byte_ptr_d = byte_ptr_q + CNT_W'(1);
                        if (byte_ptr_q == n_q - CNT_W'(1)) state_d = StDone;
                    end
                end
`ifdef OPERAND_INDEX_ADD_EN
                StIndex: begin
                    addr_lo_d    = idx_sum[DATA_W-1:0];
                    addr_hi_d    = lanes_q[1] + DATA_W'(idx_sum[DATA_W]);
                    page_cross_d = idx_sum[DATA_W];
                    state_d      = StFull;
                end
`endif
                StFull: begin
                    if (bus.consume) begin
                        state_d = StIdle;
                    end else if (capture) begin
                        overflow_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge fclk) begin
        if (reset) begin
            state_q    <= StIdle;
            lanes_q    <= '0;
            byte_ptr_q <= '0;
            n_q        <= '0;
            overflow_q <= 1'b0;
`ifdef OPERAND_INDEX_ADD_EN
            addr_lo_q    <= '0;
            addr_hi_q    <= '0;
            page_cross_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            lanes_q    <= lanes_d;
            byte_ptr_q <= byte_ptr_d;
            n_q        <= n_d;
            overflow_q <= overflow_d;
`ifdef OPERAND_INDEX_ADD_EN
            addr_lo_q    <= addr_lo_d;
            addr_hi_q    <= addr_hi_d;
            page_cross_q <= page_cross_d;
`endif
        end
    end

    assign bus.db_out        = lanes_q[0];
    assign bus.operand_out   = lanes_q;
    assign bus.byte_ptr      = byte_ptr_q;
    assign bus.busy          = (state_q == StCollect) || (state_q == StIndex);
    assign bus.operand_valid = (state_q == StFull);
    assign bus.overflow      = overflow_q;

`ifdef OPERAND_INDEX_ADD_EN
    assign bus.address_low_out  = addr_lo_q;
    assign bus.address_high_out = addr_hi_q;
    assign bus.page_cross       = page_cross_q;
`else
    assign bus.address_low_out  = lanes_q[0];
    assign bus.address_high_out = lanes_q[1];
    assign bus.page_cross       = 1'b0;
`endif

endmodule

// File: tb/tb_operand_assembly_latch.sv
// Directed bench for operand_assembly_latch with an expected-operand scoreboard queue.
module tb_operand_assembly_latch;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned MAX_BYTES = 2;
    localparam int unsigned CNT_W     = 3;

    logic fclk;
    logic reset;
    int   compared;
    int   mismatched;
    logic [15:0] sb_q[$];

    operand_assembly_latch_if #(
        .DATA_W(DATA_W), .MAX_BYTES(MAX_BYTES), .CNT_W(CNT_W)
    ) bus ();

    operand_assembly_latch #(
        .DATA_W(DATA_W), .MAX_BYTES(MAX_BYTES), .CNT_W(CNT_W)
    ) dut (
        .fclk (fclk),
        .reset(reset),
        .bus  (bus)
    );

    initial fclk = 1'b0;
    always #5 fclk = ~fclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        compared++;
        assert (obs === exp_v) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic cyc();
        @(posedge fclk);
        #1;
    endtask

    task automatic do_start(input logic [CNT_W-1:0] n);
        bus.start        = 1'b1;
        bus.expect_bytes = n;
        cyc();
        bus.start        = 1'b0;
    endtask

    task automatic do_load(input logic [7:0] d, input logic rw);
        bus.load  = 1'b1;
        bus.rwb   = rw;
        bus.db_in = d;
        cyc();
        bus.load  = 1'b0;
        bus.rwb   = 1'b1;
    endtask

    task automatic sb_pop(input string tag);
        logic [15:0] e;
        if (sb_q.size() == 0) begin
            check({tag, "_sb_nonempty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check(tag, {16'd0, bus.operand_out}, {16'd0, e});
        end
    endtask

    // Final capture: operand_valid must appear exactly at the modelled latency.
    task automatic final_load(input logic [7:0] d, input string tag);
        do_load(d, 1'b1);
`ifdef OPERAND_INDEX_ADD_EN
        check({tag, "_valid_early"}, {31'd0, bus.operand_valid}, 32'd0);
        cyc();
`endif
        check({tag, "_valid"}, {31'd0, bus.operand_valid}, 32'd1);
        sb_pop({tag, "_operand"});
    endtask

    initial begin
        compared     = 0;
        mismatched   = 0;
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.expect_bytes = '0;
        bus.load     = 1'b0;
        bus.rwb      = 1'b1;
        bus.db_in    = '0;
        bus.consume  = 1'b0;
        bus.clear    = 1'b0;
        bus.index_in = '0;
        cyc();
        cyc();
        reset = 1'b0;
        cyc();

        check("rst_busy",     {31'd0, bus.busy}, 32'd0);
        check("rst_valid",    {31'd0, bus.operand_valid}, 32'd0);
        check("rst_overflow", {31'd0, bus.overflow}, 32'd0);
        check("rst_ptr",      {29'd0, bus.byte_ptr}, 32'd0);
        check("rst_operand",  {16'd0, bus.operand_out}, 32'd0);
        check("rst_pcross",   {31'd0, bus.page_cross}, 32'd0);

        // Basic two-byte operand 0x1234
        do_start(3'd2);
        check("t1_busy", {31'd0, bus.busy}, 32'd1);
        do_load(8'h34, 1'b1);
        check("t1_ptr1", {29'd0, bus.byte_ptr}, 32'd1);
        check("t1_not_valid", {31'd0, bus.operand_valid}, 32'd0);
        sb_q.push_back(16'h1234);
        final_load(8'h12, "t1");
        check("t1_addr_hi", {24'd0, bus.address_high_out}, 32'h12);
        check("t1_addr_lo", {24'd0, bus.address_low_out}, 32'h34);
        check("t1_db_out",  {24'd0, bus.db_out}, 32'h34);
        check("t1_ptr2",    {29'd0, bus.byte_ptr}, 32'd2);

        // Load while FULL -> sticky overflow, data unchanged
        do_load(8'h99, 1'b1);
        check("ovf_set",     {31'd0, bus.overflow}, 32'd1);
        check("ovf_operand", {16'd0, bus.operand_out}, 32'h1234);
        check("ovf_valid",   {31'd0, bus.operand_valid}, 32'd1);
        bus.consume = 1'b1;
        cyc();
        bus.consume = 1'b0;
        check("cons_valid",   {31'd0, bus.operand_valid}, 32'd0);
        check("cons_busy",    {31'd0, bus.busy}, 32'd0);
        check("cons_addr_hi", {24'd0, bus.address_high_out}, 32'h12);
        check("cons_addr_lo", {24'd0, bus.address_low_out}, 32'h34);
        do_start(3'd2);
        check("restart_ovf",     {31'd0, bus.overflow}, 32'd0);
        check("restart_operand", {16'd0, bus.operand_out}, 32'd0);

        // Write-direction load is ignored
        do_load(8'hAA, 1'b0);
        check("rwb0_ptr", {29'd0, bus.byte_ptr}, 32'd0);
        do_load(8'h55, 1'b1);
        check("rwb1_ptr",  {29'd0, bus.byte_ptr}, 32'd1);
        check("rwb1_lane0", {24'd0, bus.db_out}, 32'h55);
        check("rwb1_busy", {31'd0, bus.busy}, 32'd1);

        // Clear mid-collect
        bus.clear = 1'b1;
        cyc();
        bus.clear = 1'b0;
        check("clr_busy",    {31'd0, bus.busy}, 32'd0);
        check("clr_ptr",     {29'd0, bus.byte_ptr}, 32'd0);
        check("clr_operand", {16'd0, bus.operand_out}, 32'd0);
        check("clr_db_out",  {24'd0, bus.db_out}, 32'd0);

        // Restart mid-collect with a same-cycle load that must be dropped
        do_start(3'd2);
        do_load(8'h77, 1'b1);
        bus.load  = 1'b1;
        bus.db_in = 8'h66;
        do_start(3'd1);
        bus.load  = 1'b0;
        check("rs_ptr",     {29'd0, bus.byte_ptr}, 32'd0);
        check("rs_operand", {16'd0, bus.operand_out}, 32'd0);
        check("rs_busy",    {31'd0, bus.busy}, 32'd1);
        sb_q.push_back(16'h0042);
        final_load(8'h42, "n1");
        bus.consume = 1'b1;
        cyc();
        bus.consume = 1'b0;

        // Saturation: expect_bytes=7 collects exactly MAX_BYTES
        do_start(3'd7);
        do_load(8'h01, 1'b1);
        check("sat_not_valid", {31'd0, bus.operand_valid}, 32'd0);
        sb_q.push_back(16'h0201);
        final_load(8'h02, "sat");
        check("sat_ptr", {29'd0, bus.byte_ptr}, 32'd2);
        bus.consume = 1'b1;
        cyc();
        bus.consume = 1'b0;

        // n=0 goes straight to FULL with a zero operand
        do_start(3'd0);
`ifdef OPERAND_INDEX_ADD_EN
        cyc();
`endif
        check("n0_valid", {31'd0, bus.operand_valid}, 32'd1);
        check("n0_busy",  {31'd0, bus.busy}, 32'd0);
        sb_q.push_back(16'h0000);
        sb_pop("n0_operand");
        bus.consume = 1'b1;
        cyc();
        bus.consume = 1'b0;

`ifdef OPERAND_INDEX_ADD_EN
        bus.index_in = 8'h20;
        do_start(3'd2);
        do_load(8'hF0, 1'b1);
        sb_q.push_back(16'h12F0);
        final_load(8'h12, "ix1");
        check("ix1_addr_hi", {24'd0, bus.address_high_out}, 32'h13);
        check("ix1_addr_lo", {24'd0, bus.address_low_out}, 32'h10);
        check("ix1_pcross",  {31'd0, bus.page_cross}, 32'd1);
        bus.consume = 1'b1;
        cyc();
        bus.consume  = 1'b0;
        bus.index_in = 8'h0F;
        do_start(3'd2);
        do_load(8'hF0, 1'b1);
        sb_q.push_back(16'h12F0);
        final_load(8'h12, "ix2");
        check("ix2_addr_hi", {24'd0, bus.address_high_out}, 32'h12);
        check("ix2_addr_lo", {24'd0, bus.address_low_out}, 32'hFF);
        check("ix2_pcross",  {31'd0, bus.page_cross}, 32'd0);
        bus.index_in = 8'h00;
`endif

        check("sb_drained", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/operand_assembly_latch.md
Name: operand_assembly_latch

Overview:
- Parametrised successor to the core's two-byte input data latch.
- Assembles a 1..MAX_BYTES little-endian operand from successive data-bus reads under an explicit start/collect/consume handshake.
- Exports the assembled operand as address high/low bytes and as a full-width word.
- Sits between the data-bus input and the address/ALU paths; the instruction decoder drives start/load/consume.

Parameters:
DATA_W, 8, width of one bus byte lane
MAX_BYTES, 2, maximum operand bytes collected (legal 2..4)
CNT_W, 3, width of expect_bytes and byte_ptr (must hold MAX_BYTES)

Ports:
fclk  in  1  core clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  begin new operand; clears lanes, latches expect_bytes
expect_bytes  in  CNT_W  bytes to collect (0..MAX_BYTES; larger saturates)
load  in  1  capture db_in into next lane (decode strobe)
rwb  in  1  bus direction; capture only when 1 (read)
db_in  in  DATA_W  data bus
consume  in  1  downstream has taken operand
clear  in  1  abort; zero lanes, return to IDLE
index_in  in  DATA_W  index register value (used only with option)
db_out  out  DATA_W  lane 0
address_low_out  out  DATA_W  effective address low byte
address_high_out  out  DATA_W  effective address high byte
operand_out  out  DATA_W*MAX_BYTES  all lanes, lane 0 in LSBs
byte_ptr  out  CNT_W  next lane to fill
busy  out  1  state is COLLECT (or INDEX)
operand_valid  out  1  state is FULL
overflow  out  1  sticky: load seen while FULL
page_cross  out  1  index add carried into high byte (option only)

Behaviour:
- Reset values: all lanes 0, byte_ptr 0, state IDLE, busy 0, operand_valid 0, overflow 0, page_cross 0; all data outputs 0.
- Priority per cycle: reset > clear > start > consume > load.
- States: IDLE, COLLECT, FULL, plus INDEX with the option.
- clear (any state): lanes 0, byte_ptr 0, overflow 0, page_cross 0, go to IDLE next cycle.
- start (any state, incl. mid-COLLECT/FULL = abort-restart):
  - lanes 0, byte_ptr 0, overflow 0.
  - latch n = min(expect_bytes, MAX_BYTES).
  - n==0 goes to FULL with operand 0; else goes to COLLECT.
  - A load in the same cycle is discarded.
- COLLECT, load && rwb:
  - lane[byte_ptr] <= db_in; byte_ptr++.
  - If byte_ptr == n-1, go to FULL (or INDEX) next cycle; operand_valid rises the cycle after the final capture.
- COLLECT, load && !rwb: ignored, no pointer change.
- Latency: last capture edge -> operand_valid = 1 cycle without option, 2 cycles with option.
- FULL:
  - operand_valid held high until consume or clear.
  - consume goes to IDLE; lanes and address outputs retained (stable until next start/clear).
  - load && rwb in FULL sets overflow; data unchanged.
- IDLE: load ignored; no overflow.
- Unfilled lanes read 0.
- byte_ptr never exceeds n and never wraps.
- address_low_out = lane0 and address_high_out = lane1 (raw) unless the option modifies them.

Optional Feature:
- Macro OPERAND_INDEX_ADD_EN.
- Defined:
  - After the final byte, state INDEX (one cycle) registers {hi,lo} + zero-extended index_in into address_high_out/address_low_out.
  - page_cross = carry out of the low-byte add; FULL is entered the next cycle.
  - operand_out and db_out stay raw.
  - n==0 or n==1 also pass through INDEX, with missing lanes treated as 0.
- Undefined: no INDEX state; addresses raw; page_cross tied 0; index_in ignored (port kept).

Test Plan:
- reset, start n=2, load 0x34 then 0x12 (rwb=1) -> operand_valid high 1 cycle after second load; addr_hi=0x12, addr_lo=0x34, db_out=0x34.
- start n=2, load 0xAA with rwb=0, then 0x55 with rwb=1 -> byte_ptr=1, lane0=0x55, still busy.
- FULL with 0x1234, load 0x99 -> overflow=1, operand unchanged; consume -> IDLE, addr outputs hold 0x1234; start -> overflow=0, lanes 0.
- mid-COLLECT after one byte: clear -> IDLE, byte_ptr 0, outputs 0. Repeat with start n=1 instead -> restart, same-cycle load discarded.
- start expect_bytes=7 (MAX_BYTES=2) -> saturates; FULL after exactly 2 loads. start n=0 -> FULL next cycle, operand 0.
- OPERAND_INDEX_ADD_EN: operand 0x12F0, index_in 0x20 -> addr 0x1310, page_cross=1, valid 2 cycles after last load. Index 0x0F -> 0x12FF, page_cross=0.
